uart_tx_frame: RTL and testbench

Parametrised UART transmitter, the successor to the fixed 8N1 transmitter. It serialises one character per valid/ready handshake and supports a configurable data width, optional odd or even parity, 1 or 2 stop bits, and a configurable oversample ratio. It sits between user logic and the `txd` pin. It is timed by an externally generated `clken_16bps`-style enable pulse, so the baud generator stays outside the block.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_bit_timer.sv | 28 ++
 rtl/uart_tx_frame.sv | 131 +++++++++++++
 tb/tb_uart_tx_frame.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive blocks: parity modes,
// frame-state encoding and legal parameter ranges.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   localparam int DATA_BITS_MIN  = 5;
   localparam int DATA_BITS_MAX  = 9;
   localparam int OVERSAMPLE_MIN = 4;
   localparam int OVERSAMPLE_MAX = 64;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_PAR   = 3'd3,
      ST_STOP  = 3'd4
   } uart_state_e;

   // Zero-extension of the character does not change the XOR reduction.
   function automatic logic par_bit(input logic odd, input logic [DATA_BITS_MAX-1:0] d);
      return odd ? ~^d : ^d;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts OVERSAMPLE enable pulses per bit and flags the last one; clr restarts
// the count and swallows an enable pulse arriving in the same cycle.
module uart_bit_timer #(
   parameter int OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic clken_os,
   output logic bit_end
);

   localparam int TW = $clog2(OVERSAMPLE);

   logic [TW-1:0] tick;

   assign bit_end = clken_os && (tick == TW'(OVERSAMPLE - 1));

   always_ff @(posedge clk) begin
      if (!rst_n)
         tick <= '0;
      else if (clr || bit_end)
         tick <= '0;
      else if (clken_os)
         tick <= tick + 1'b1;
   end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS data LSB first, optional
// parity, 1 or 2 stop bits, paced by an external oversample enable.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clken_os,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 txd,
   output logic                 tx_busy,
   output logic                 tx_done
);

   if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
      $error("uart_tx_frame: DATA_BITS must be 5..9");
   end
   if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end
   if (OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX) begin : g_bad_oversample
      $error("uart_tx_frame: OVERSAMPLE must be 4..64");
   end

   localparam int BCW     = $clog2(DATA_BITS);
   localparam bit HAS_PAR = (PARITY != PAR_NONE);
   localparam bit IS_ODD  = (PARITY == PAR_ODD);

   uart_state_e          state;
   logic [DATA_BITS-1:0] shreg;
   logic                 par;
   logic [BCW-1:0]       bit_cnt;
   logic                 stop_cnt;
   logic                 accept;
   logic                 bit_end;

   assign tx_ready = (state == ST_IDLE);
   assign tx_busy  = (state != ST_IDLE);
   assign accept   = tx_valid && tx_ready;

   uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (accept),
      .clken_os (clken_os),
      .bit_end  (bit_end)
   );

   // txd is loaded with the level of the state being entered, so the line
   // changes on the same edge as the state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         txd      <= 1'b1;
         tx_done  <= 1'b0;
         shreg    <= '0;
         par      <= 1'b0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (tx_valid) begin
                  shreg    <= tx_data;
                  par      <= par_bit(IS_ODD, DATA_BITS_MAX'(tx_data));
                  bit_cnt  <= '0;
                  stop_cnt <= 1'b0;
                  state    <= ST_START;
                  txd      <= 1'b0;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  state <= ST_DATA;
                  txd   <= shreg[0];
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  if (bit_cnt == BCW'(DATA_BITS - 1)) begin
                     if (HAS_PAR) begin
                        state <= ST_PAR;
                        txd   <= par;
                     end else begin
                        state <= ST_STOP;
                        txd   <= 1'b1;
                     end
                  end else begin
                     shreg   <= shreg >> 1;
                     bit_cnt <= bit_cnt + 1'b1;
                     txd     <= shreg[1];
                  end
               end
            end
            ST_PAR: begin
               if (bit_end) begin
                  state <= ST_STOP;
                  txd   <= 1'b1;
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  if (stop_cnt == 1'(STOP_BITS - 1)) begin
                     state   <= ST_IDLE;
                     tx_done <= 1'b1;
                  end else begin
                     stop_cnt <= stop_cnt + 1'b1;
                  end
                  txd <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               txd   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: five parameter variants side by side,
// table-driven frames plus back-to-back, busy-ignore and mid-frame reset.
module tb_uart_tx_frame;

   logic       clk = 1'b0;
   logic [1:0] ckc = 2'd0;
   logic       ck0;
   logic       ck_hi;
   logic [4:0] rstn, vld, txd, rdy, busy, done;
   logic [7:0] dat [5];
   logic [6:0] dat7;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) ckc <= ckc + 2'd1;
   assign ck0   = (ckc == 2'd0);
   assign ck_hi = 1'b1;

   uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)) u0 (
      .clk(clk), .rst_n(rstn[0]), .clken_os(ck0), .tx_valid(vld[0]), .tx_data(dat[0]),
      .tx_ready(rdy[0]), .txd(txd[0]), .tx_busy(busy[0]), .tx_done(done[0]));
   uart_tx_frame #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(4)) u1 (
      .clk(clk), .rst_n(rstn[1]), .clken_os(ck_hi), .tx_valid(vld[1]), .tx_data(dat[1]),
      .tx_ready(rdy[1]), .txd(txd[1]), .tx_busy(busy[1]), .tx_done(done[1]));
   uart_tx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(4)) u2 (
      .clk(clk), .rst_n(rstn[2]), .clken_os(ck_hi), .tx_valid(vld[2]), .tx_data(dat[2]),
      .tx_ready(rdy[2]), .txd(txd[2]), .tx_busy(busy[2]), .tx_done(done[2]));
   uart_tx_frame #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(4)) u3 (
      .clk(clk), .rst_n(rstn[3]), .clken_os(ck_hi), .tx_valid(vld[3]), .tx_data(dat7),
      .tx_ready(rdy[3]), .txd(txd[3]), .tx_busy(busy[3]), .tx_done(done[3]));
   uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(4)) u4 (
      .clk(clk), .rst_n(rstn[4]), .clken_os(ck_hi), .tx_valid(vld[4]), .tx_data(dat[4]),
      .tx_ready(rdy[4]), .txd(txd[4]), .tx_busy(busy[4]), .tx_done(done[4]));

   // frame bit i is the i-th bit on the line (bit 0 = start bit)
   typedef struct {
      int          k;
      logic [7:0]  d;
      int          nbits;
      int          bl;
      logic [11:0] frame;
      int          inj;
   } vec_t;

   vec_t tv [8];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic set_in(input int k, input logic v, input logic [7:0] d);
      vld[k] = v;
      if (k == 3) dat7 = d[6:0];
      else        dat[k] = d;
   endtask

   // Returns at the first negedge after the accept edge.
   task automatic send(input int k, input logic [7:0] d);
      @(negedge clk);
      chk("ready_idle", int'(rdy[k]), 1);
      set_in(k, 1'b1, d);
      @(negedge clk);
      set_in(k, 1'b0, 8'h00);
   endtask

   task automatic run_frame(input vec_t v);
      logic [11:0] got;
      int ndone, nbusy, lim, lo;
      got   = '0;
      ndone = 0;
      nbusy = 0;
      lim   = v.nbits * v.bl + 8;
      send(v.k, v.d);
      for (int n = 0; n <= lim; n++) begin
         if ((n % v.bl) == v.bl / 2 && n / v.bl < v.nbits) got[n / v.bl] = txd[v.k];
         ndone += int'(done[v.k]);
         nbusy += int'(busy[v.k]);
         if (n == v.inj) begin
            chk("ready_while_busy", int'(rdy[v.k]), 0);
            set_in(v.k, 1'b1, 8'h12);
         end else if (n == v.inj + 1) begin
            set_in(v.k, 1'b0, 8'h00);
         end
         @(negedge clk);
      end
      lo = (v.bl == 4) ? v.nbits * v.bl : v.nbits * v.bl - 4;
      chk("frame_bits", int'(got), int'(v.frame));
      chk("done_pulses", ndone, 1);
      chk_range("busy_cycles", nbusy, lo, v.nbits * v.bl);
      chk("txd_idle_after", int'(txd[v.k]), 1);
   endtask

   initial begin
      int   ndone, bad;
      logic e;

      tv[0] = '{0, 8'h55, 10, 64, {2'b00, 1'b1, 8'h55, 1'b0}, -1};
      tv[1] = '{1, 8'hA3, 11, 4,  {1'b0, 1'b1, 1'b0, 8'hA3, 1'b0}, -1};
      tv[2] = '{2, 8'hA3, 11, 4,  {1'b0, 1'b1, 1'b1, 8'hA3, 1'b0}, -1};
      tv[3] = '{1, 8'h07, 11, 4,  {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, -1};
      tv[4] = '{2, 8'h00, 11, 4,  {1'b0, 1'b1, 1'b1, 8'h00, 1'b0}, -1};
      tv[5] = '{4, 8'h01, 10, 4,  {2'b00, 1'b1, 8'h01, 1'b0}, -1};
      tv[6] = '{4, 8'h3C, 10, 4,  {2'b00, 1'b1, 8'h3C, 1'b0}, 10};
      tv[7] = '{3, 8'h55, 10, 4,  {2'b00, 2'b11, 7'h55, 1'b0}, -1};

      rstn = '0;
      vld  = '0;
      dat7 = '0;
      for (int i = 0; i < 5; i++) dat[i] = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_txd", int'(txd), 'h1F);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      rstn = '1;
      @(negedge clk);
      chk("reset_ready", int'(rdy), 'h1F);

      for (int i = 0; i < 8; i++) run_frame(tv[i]);

      // back-to-back on the 7-bit, 2-stop variant with tx_valid held
      @(negedge clk);
      set_in(3, 1'b1, 8'h7F);
      @(negedge clk);
      dat7  = 7'h00;
      ndone = 0;
      bad   = 0;
      for (int n = 0; n <= 82; n++) begin
         e = (n < 4) ? 1'b0 : (n <= 40) ? 1'b1 : (n <= 72) ? 1'b0 : 1'b1;
         if (txd[3] !== e) bad++;
         ndone += int'(done[3]);
         if (n == 40) begin
            chk("b2b_done_at_40", int'(done[3]), 1);
            chk("b2b_ready_with_done", int'(rdy[3]), 1);
         end
         if (n == 41) begin
            chk("b2b_second_start", int'(txd[3]), 0);
            vld[3] = 1'b0;
         end
         @(negedge clk);
      end
      chk("b2b_waveform_errs", bad, 0);
      chk("b2b_done_pulses", ndone, 2);

      // reset for one cycle during data bit 3
      send(4, 8'hAA);
      ndone = 0;
      bad   = 0;
      for (int n = 0; n <= 60; n++) begin
         if (n == 17) rstn[4] = 1'b0;
         if (n == 18) begin
            rstn[4] = 1'b1;
            chk("rst_txd_high", int'(txd[4]), 1);
            chk("rst_ready", int'(rdy[4]), 1);
            chk("rst_busy", int'(busy[4]), 0);
         end
         if (n >= 18 && txd[4] !== 1'b1) bad++;
         ndone += int'(done[4]);
         @(negedge clk);
      end
      chk("rst_no_done", ndone, 0);
      chk("rst_line_idle", bad, 0);
      run_frame('{4, 8'hC3, 10, 4, {2'b00, 1'b1, 8'hC3, 1'b0}, -1});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
